// File: rtl/spi_reg_bridge.sv
// SPI byte-stream to register-bus bridge: byte 0 is the command, later bytes are write data or read clocks.
// Build option SPI_REG_BRIDGE_AUTOINC_EN: step the register address after every bus access.
module spi_reg_bridge #(
  parameter int          ADDR_W  = 7,
  parameter logic [7:0]  IDLE_TX = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic              bus_ack,
  input  logic [7:0]        bus_rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, CMD, WR_DATA, WR_BUS, RD_BUS, RD_STREAM, DRAIN
  } state_t;

  state_t            state, state_nxt;
  logic              ss_s1, ss_s2, ss_d;
  logic              frame_start, frame_end;
  logic              start_pend, start_pend_nxt;
  logic [7:0]        tx_nxt, wdata_nxt;
  logic              req_nxt, we_nxt, err_nxt, busy_nxt;
  logic [ADDR_W-1:0] addr_nxt, addr_step;

  assign frame_start = ss_d & ~ss_s2;
  assign frame_end   = ~ss_d & ss_s2;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  assign addr_step = bus_addr + 1'b1;
`else
  assign addr_step = bus_addr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_s1      <= 1'b1;
      ss_s2      <= 1'b1;
      ss_d       <= 1'b1;
      state      <= IDLE;
      start_pend <= 1'b0;
      tx_data    <= IDLE_TX;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= 8'h00;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ss_s1      <= ss;
      ss_s2      <= ss_s1;
      ss_d       <= ss_s2;
      state      <= state_nxt;
      start_pend <= start_pend_nxt;
      tx_data    <= tx_nxt;
      bus_req    <= req_nxt;
      bus_we     <= we_nxt;
      bus_addr   <= addr_nxt;
      bus_wdata  <= wdata_nxt;
      busy       <= busy_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    start_pend_nxt = start_pend;
    tx_nxt         = tx_data;
    req_nxt        = bus_req;
    we_nxt         = bus_we;
    addr_nxt       = bus_addr;
    wdata_nxt      = bus_wdata;
    err_nxt        = err;

    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = CMD;
          err_nxt   = 1'b0;
        end
      end
      CMD: begin
        if (rx_done) begin
          addr_nxt = rx_data[ADDR_W-1:0];
          if (rx_data[7]) begin
            req_nxt   = 1'b1;
            we_nxt    = 1'b0;
            state_nxt = RD_BUS;
          end else begin
            state_nxt = WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (rx_done) begin
          wdata_nxt = rx_data;
          req_nxt   = 1'b1;
          we_nxt    = 1'b1;
          state_nxt = WR_BUS;
        end
      end
      WR_BUS: begin
        // A byte landing before the previous write finished is dropped.
        if (rx_done) err_nxt = 1'b1;
        if (bus_ack) begin
          req_nxt   = 1'b0;
          addr_nxt  = addr_step;
          state_nxt = WR_DATA;
        end
      end
      RD_BUS: begin
        if (bus_ack) begin
          tx_nxt    = bus_rdata;
          req_nxt   = 1'b0;
          addr_nxt  = addr_step;
          state_nxt = RD_STREAM;
        end
        // Underrun: the slave already took a byte, so the read data is stale.
        if (rx_done) begin
          err_nxt = 1'b1;
          tx_nxt  = IDLE_TX;
        end
      end
      RD_STREAM: begin
        if (rx_done) begin
          req_nxt   = 1'b1;
          we_nxt    = 1'b0;
          state_nxt = RD_BUS;
        end
      end
      DRAIN: begin
        if (frame_start) start_pend_nxt = 1'b1;
        if (frame_end)   start_pend_nxt = 1'b0;
        if (bus_ack) begin
          req_nxt        = 1'b0;
          start_pend_nxt = 1'b0;
          if (start_pend || frame_start) begin
            state_nxt = CMD;
            err_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Frame end overrides whatever the byte handling above decided.
    if (frame_end && state != IDLE && state != DRAIN) begin
      tx_nxt         = IDLE_TX;
      start_pend_nxt = 1'b0;
      if (bus_req && !bus_ack) begin
        req_nxt   = 1'b1;
        state_nxt = DRAIN;
      end else begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: bus transactions and MISO bytes are predicted from a register-array model.
// Handshake: bus_req rises with we/addr/wdata stable and stays high until the one-cycle bus_ack.
module tb_spi_reg_bridge;
  localparam int         ADDR_W  = 7;
  localparam logic [7:0] IDLE_TX = 8'hFF;
  localparam int         GAP     = 20;

  logic              clk, rst, ss, rx_done, bus_ack;
  logic [7:0]        rx_data, bus_rdata, tx_data, bus_wdata;
  logic              bus_req, bus_we, busy, err;
  logic [ADDR_W-1:0] bus_addr;

  spi_reg_bridge #(.ADDR_W(ADDR_W), .IDLE_TX(IDLE_TX)) dut (
    .clk(clk), .rst(rst), .ss(ss), .rx_done(rx_done), .rx_data(rx_data),
    .tx_data(tx_data), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .busy(busy), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_bus_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  regs[128];
  logic [7:0]  model_regs[128];
  logic [7:0]  dbuf[8];
  int ack_min = 1;
  int ack_max = 6;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] addr_at(input logic [6:0] s, input int k);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    return s + 7'(k);
`else
    return (k >= 0) ? s : s;
`endif
  endfunction

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    wait_cyc(1);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b);
    pulse_byte(b);
    wait_cyc(GAP - 1);
  endtask

  task automatic wait_idle(input int limit);
    int c = 0;
    while (busy !== 1'b0 && c < limit) begin
      wait_cyc(1);
      c++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic ss_fall();
    ss = 1'b0;
    wait_cyc(4);
    check("busy_start", busy, 1);
    check("err_clear_start", err, 0);
  endtask

  task automatic ss_rise();
    ss = 1'b1;
    wait_cyc(4);
  endtask

  // One well-paced frame: command plus n data bytes, predictions pushed up front.
  task automatic do_frame(input logic [7:0] cmd, input int n);
    logic [6:0] s;
    logic [6:0] a;
    s = cmd[6:0];
    ss_fall();
    exp_tx_q.push_back(IDLE_TX);
    if (cmd[7]) begin
      for (int k = 0; k <= n; k++) exp_bus_q.push_back({1'b0, addr_at(s, k), 8'h00});
      for (int k = 1; k <= n; k++) exp_tx_q.push_back(model_regs[addr_at(s, k - 1)]);
    end else begin
      for (int i = 0; i < n; i++) begin
        a = addr_at(s, i);
        exp_bus_q.push_back({1'b1, a, dbuf[i]});
        model_regs[a] = dbuf[i];
        exp_tx_q.push_back(IDLE_TX);
      end
    end
    send_byte(cmd);
    for (int i = 0; i < n; i++) send_byte(cmd[7] ? 8'($urandom) : dbuf[i]);
    ss_rise();
    wait_idle(100);
    check("err_after_frame", err, 0);
    check("tx_idle_after_frame", tx_data, IDLE_TX);
  endtask

  // bus responder: acks after a random delay, aborts if the request vanishes
  int  ack_d;
  bit  aborted;
  initial begin
    bus_ack = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus_req === 1'b1) begin
        ack_d = $urandom_range(ack_min, ack_max);
        aborted = 1'b0;
        repeat (ack_d) begin
          @(negedge clk);
          if (bus_req !== 1'b1) aborted = 1'b1;
        end
        if (!aborted) begin
          @(posedge clk);
          #1;
          bus_ack = 1'b1;
          bus_rdata = bus_we ? 8'($urandom) : regs[bus_addr];
          if (bus_we) regs[bus_addr] = bus_wdata;
          @(posedge clk);
          #1;
          bus_ack = 1'b0;
          bus_rdata = 8'($urandom);
        end
      end
    end
  end

  // scoreboard monitors
  always @(negedge clk) begin
    if (bus_req === 1'b1 && bus_ack === 1'b1) begin
      if (exp_bus_q.size() == 0) begin
        check("bus_unexpected", {bus_we, bus_addr, bus_wdata}, 16'h0000);
        if ({bus_we, bus_addr, bus_wdata} === 16'h0000) check("bus_unexpected", 1, 0);
      end else begin
        check("bus_txn", {bus_we, bus_addr, (bus_we ? bus_wdata : 8'h00)}, exp_bus_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      if (exp_tx_q.size() == 0) check("tx_unexpected", 1, 0);
      else check("tx_byte", tx_data, exp_tx_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timed out at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $finish;
  end

  initial begin
    logic [7:0] cmd;
    int n;
    rst = 1'b1; ss = 1'b1; rx_done = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < 128; i++) begin
      regs[i] = 8'($urandom);
      model_regs[i] = regs[i];
    end
    wait_cyc(3);
    check("rst_tx", tx_data, IDLE_TX);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    wait_cyc(3);

    // write burst
    dbuf[0] = 8'hA1; dbuf[1] = 8'hB2;
    do_frame(8'h05, 2);

    // read burst
    regs[8'h10] = 8'h3C; model_regs[8'h10] = 8'h3C;
    regs[8'h11] = 8'h4D; model_regs[8'h11] = 8'h4D;
    do_frame(8'h90, 3);

    // address wrap
    do_frame(8'hFF, 3);

    // empty frame and command-only frame
    ss_fall();
    ss_rise();
    wait_idle(50);
    check("empty_err", err, 0);
    do_frame(8'h12, 0);

    // rx_done while deselected
    exp_tx_q.push_back(IDLE_TX);
    pulse_byte(8'h85);
    wait_cyc(10);
    check("idle_rx_busy", busy, 0);
    check("idle_rx_req", bus_req, 0);

    // read underrun
    ack_min = GAP + 10; ack_max = GAP + 10;
    ss_fall();
    exp_tx_q.push_back(IDLE_TX);
    exp_tx_q.push_back(IDLE_TX);
    exp_bus_q.push_back({1'b0, 7'h22, 8'h00});
    send_byte(8'hA2);
    send_byte(8'h00);
    check("underrun_err", err, 1);
    ss_rise();
    wait_idle(100);
    check("underrun_err_sticky", err, 1);
    check("underrun_tx_idle", tx_data, IDLE_TX);
    ack_min = 1; ack_max = 6;
    dbuf[0] = 8'h77;
    do_frame(8'h40, 1);

    // abort with a write outstanding
    ack_min = 16; ack_max = 16;
    ss_fall();
    exp_tx_q.push_back(IDLE_TX);
    exp_tx_q.push_back(IDLE_TX);
    exp_bus_q.push_back({1'b1, 7'h20, 8'h5A});
    model_regs[8'h20] = 8'h5A;
    send_byte(8'h20);
    pulse_byte(8'h5A);
    wait_cyc(1);
    ss = 1'b1;
    wait_cyc(5);
    check("abort_req_held", bus_req, 1);
    check("abort_busy_held", busy, 1);
    wait_idle(60);
    check("abort_req_dropped", bus_req, 0);

    // frame restarted while draining
    ss_fall();
    exp_tx_q.push_back(IDLE_TX);
    exp_tx_q.push_back(IDLE_TX);
    exp_bus_q.push_back({1'b1, 7'h30, 8'hC3});
    model_regs[8'h30] = 8'hC3;
    send_byte(8'h30);
    pulse_byte(8'hC3);
    wait_cyc(1);
    ss = 1'b1;
    wait_cyc(4);
    ss = 1'b0;
    wait_cyc(40);
    check("drain_restart_busy", busy, 1);
    check("drain_restart_req", bus_req, 0);
    ack_min = 1; ack_max = 6;
    dbuf[0] = 8'h6E;
    exp_tx_q.push_back(IDLE_TX);
    exp_tx_q.push_back(IDLE_TX);
    exp_bus_q.push_back({1'b1, 7'h31, 8'h6E});
    model_regs[8'h31] = 8'h6E;
    send_byte(8'h31);
    send_byte(8'h6E);
    ss_rise();
    wait_idle(100);
    check("drain_restart_err", err, 0);

    // reset in the middle of a read stream
    ss_fall();
    exp_tx_q.push_back(IDLE_TX);
    exp_bus_q.push_back({1'b0, 7'h11, 8'h00});
    send_byte(8'h91);
    exp_tx_q.push_back(model_regs[8'h11]);
    ack_min = 12; ack_max = 12;
    pulse_byte(8'h00);
    wait_cyc(2);
    check("pre_rst_req", bus_req, 1);
    rst = 1'b1;
    wait_cyc(1);
    check("mid_rst_req", bus_req, 0);
    check("mid_rst_tx", tx_data, IDLE_TX);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    rst = 1'b0;
    ss = 1'b1;
    wait_cyc(20);
    ack_min = 1; ack_max = 6;
    dbuf[0] = 8'h99;
    do_frame(8'h33, 1);

    // randomized frames
    ack_max = 8;
    repeat (40) begin
      cmd = 8'($urandom);
      n = cmd[7] ? $urandom_range(1, 4) : $urandom_range(0, 4);
      for (int i = 0; i < 8; i++) dbuf[i] = 8'($urandom);
      do_frame(cmd, n);
    end

    wait_cyc(20);
    check("bus_q_drained", exp_bus_q.size(), 0);
    check("tx_q_drained", exp_tx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
